// File: rtl/ssd1306_pkg.sv
// ----------------------------------------------------------------------------
// ssd1306_pkg
//   Shared definitions for the SSD1306 display endpoint model: command
//   opcodes, addressing-mode and command-FSM enums, the decoded per-byte
//   control bundle, and a helper that recognises single-argument commands
//   whose argument this model does not need.
// ----------------------------------------------------------------------------
package ssd1306_pkg;

  localparam logic [7:0] CMD_MODE     = 8'h20;
  localparam logic [7:0] CMD_COL      = 8'h21;
  localparam logic [7:0] CMD_PAGE     = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;

  typedef enum logic [1:0] {
    HORIZ = 2'd0,
    VERT  = 2'd1,
    PAGE  = 2'd2
  } addr_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    ARG_MODE,
    ARG_COL_S,
    ARG_COL_E,
    ARG_PG_S,
    ARG_PG_E,
    ARG_SKIP
  } rx_state_t;

  // One-hot-ish set of register updates decoded from a received byte.
  typedef struct packed {
    logic wr;
    logic set_mode;
    logic set_col_s;
    logic set_col_e;
    logic set_pg_s;
    logic set_pg_e;
    logic set_page_b;
    logic set_col_lo;
    logic set_col_hi;
    logic set_disp;
  } ctrl_t;

  // Commands followed by exactly one argument byte that is simply dropped.
  function automatic logic has_skip_arg(input logic [7:0] op);
    case (op)
      8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_rx_spi_byte_rx.sv
// ----------------------------------------------------------------------------
// spi_byte_rx
//   SPI mode-0 byte receiver. SCK, MOSI and DC (and CS_n when present) pass
//   through the same SYNC_STAGES-deep synchroniser so they stay aligned; MOSI
//   and DC are sampled on each detected SCK rising edge, MSB first. The 8th
//   edge completes the byte and rx_dv pulses for one cycle afterwards.
//   Optional feature macro: SSD1306_RX_CS_EN adds cs_n; while it is high SCK
//   edges are ignored and the bit count is held at 0.
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   sck, mosi, dc     raw SPI clock, data and data/command select
//   cs_n              chip select, active low (SSD1306_RX_CS_EN only)
//   rx_byte           last completed byte
//   rx_dv             1-cycle pulse, rx_byte/rx_is_data valid
//   rx_is_data        DC value sampled with the 8th bit
// ----------------------------------------------------------------------------
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       mosi,
  input  logic       dc,
`ifdef SSD1306_RX_CS_EN
  input  logic       cs_n,
`endif
  output logic [7:0] rx_byte,
  output logic       rx_dv,
  output logic       rx_is_data
);

  logic       cs_raw;
  logic [3:0] raw_in;
  logic [3:0] synced;

`ifdef SSD1306_RX_CS_EN
  assign cs_raw = cs_n;
`else
  assign cs_raw = 1'b0;
`endif

  assign raw_in = {cs_raw, dc, mosi, sck};

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign synced = raw_in;
    end else begin : g_sync
      logic [3:0] stage_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        // NOTE: the synchroniser is only a few flops, so it is cleared on
        // reset like any other register; large RAMs are never reset.
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= raw_in;
          for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign synced = stage_q[SYNC_STAGES-1];
    end
  endgenerate

  logic       sck_s, mosi_s, dc_s, cs_s;
  logic       sck_prev_q;
  logic       sck_rise;
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;

  assign {cs_s, dc_s, mosi_s, sck_s} = synced;
  assign sck_rise = sck_s & ~sck_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_prev_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rx_byte    <= '0;
      rx_dv      <= 1'b0;
      rx_is_data <= 1'b0;
    end else begin
      sck_prev_q <= sck_s;
      rx_dv      <= 1'b0;
      if (cs_s) begin
        // Deselect discards any partial byte.
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte    <= {shift_q, mosi_s};
          rx_is_data <= dc_s;
          rx_dv      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ssd1306_rx.sv
// ----------------------------------------------------------------------------
// ssd1306_rx
//   Behavioural SSD1306 display endpoint. Receives SPI bytes through
//   spi_byte_rx, decodes the addressing-command subset with a small command
//   FSM, and turns data bytes into GDDRAM write strobes for a frame buffer.
//   Optional feature macro: SSD1306_RX_CS_EN adds the i_CS_n port.
// Ports
//   i_Clk, i_Reset    system clock, synchronous active-high reset
//   i_SPI_Clk         D0, SCK (idle low)
//   i_SPI_MOSI        D1, MSB first
//   i_DC              1 = data byte, 0 = command byte
//   i_CS_n            chip select, active low (SSD1306_RX_CS_EN only)
//   o_Byte            last completed byte
//   o_Byte_DV         1-cycle pulse, o_Byte/o_Is_Data valid
//   o_Is_Data         DC value of o_Byte
//   o_Wr_En           1-cycle GDDRAM write strobe
//   o_Wr_Addr         page*COLS+col
//   o_Wr_Data         pixel byte, bit0 = top row of page
//   o_Display_On      set by 0xAF, cleared by 0xAE
// ----------------------------------------------------------------------------
module ssd1306_rx
  import ssd1306_pkg::*;
#(
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            i_Clk,
  input  logic                            i_Reset,
  input  logic                            i_SPI_Clk,
  input  logic                            i_SPI_MOSI,
  input  logic                            i_DC,
`ifdef SSD1306_RX_CS_EN
  input  logic                            i_CS_n,
`endif
  output logic [7:0]                      o_Byte,
  output logic                            o_Byte_DV,
  output logic                            o_Is_Data,
  output logic                            o_Wr_En,
  output logic [$clog2(COLS*PAGES)-1:0]   o_Wr_Addr,
  output logic [7:0]                      o_Wr_Data,
  output logic                            o_Display_On
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [PW-1:0] PAGE_ONE = PW'(1);

  logic [7:0] rx_byte;
  logic       rx_dv;
  logic       rx_is_data;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_spi (
    .clk        (i_Clk),
    .reset      (i_Reset),
    .sck        (i_SPI_Clk),
    .mosi       (i_SPI_MOSI),
    .dc         (i_DC),
`ifdef SSD1306_RX_CS_EN
    .cs_n       (i_CS_n),
`endif
    .rx_byte    (rx_byte),
    .rx_dv      (rx_dv),
    .rx_is_data (rx_is_data)
  );

  rx_state_t     state_q, state_d;
  ctrl_t         ctrl;
  addr_mode_t    mode_q;
  logic [CW-1:0] col_q, col_s_q, col_e_q;
  logic [PW-1:0] page_q, pg_s_q, pg_e_q;
  logic          disp_q;
  logic [7:0]    col_ext;
  logic          is_cmd;

  assign is_cmd  = rx_dv & ~rx_is_data;
  assign col_ext = 8'(col_q);

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic. A data byte always returns to IDLE, aborting any
  // command still waiting for its argument.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    if (rx_dv) begin
      if (rx_is_data) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if      (rx_byte == CMD_MODE)  state_d = ARG_MODE;
            else if (rx_byte == CMD_COL)   state_d = ARG_COL_S;
            else if (rx_byte == CMD_PAGE)  state_d = ARG_PG_S;
            else if (has_skip_arg(rx_byte)) state_d = ARG_SKIP;
            else                            state_d = IDLE;
          end
          ARG_COL_S: state_d = ARG_COL_E;
          ARG_PG_S:  state_d = ARG_PG_E;
          default:   state_d = IDLE;
        endcase
      end
    end
  end

  // Output decode: which register update this byte requests.
  always_comb begin
    ctrl            = '0;
    ctrl.wr         = rx_dv & rx_is_data;
    ctrl.set_mode   = is_cmd && (state_q == ARG_MODE) && (rx_byte[1:0] != 2'd3);
    ctrl.set_col_s  = is_cmd && (state_q == ARG_COL_S);
    ctrl.set_col_e  = is_cmd && (state_q == ARG_COL_E);
    ctrl.set_pg_s   = is_cmd && (state_q == ARG_PG_S);
    ctrl.set_pg_e   = is_cmd && (state_q == ARG_PG_E);
    ctrl.set_page_b = is_cmd && (state_q == IDLE) && (rx_byte[7:3] == 5'b10110);
    ctrl.set_col_lo = is_cmd && (state_q == IDLE) && (rx_byte[7:4] == 4'h0);
    ctrl.set_col_hi = is_cmd && (state_q == IDLE) && (rx_byte[7:4] == 4'h1);
    ctrl.set_disp   = is_cmd && (state_q == IDLE) &&
                      ((rx_byte == CMD_DISP_ON) || (rx_byte == CMD_DISP_OFF));
  end

  // Address pointers, window registers and mode. The pointer advances on
  // the same cycle o_Wr_En is high, so back-to-back writes never collide.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mode_q  <= PAGE;
      col_q   <= '0;
      page_q  <= '0;
      col_s_q <= '0;
      col_e_q <= '1;
      pg_s_q  <= '0;
      pg_e_q  <= '1;
      disp_q  <= 1'b0;
    end else if (ctrl.wr) begin
      case (mode_q)
        HORIZ: begin
          if (col_q == col_e_q) begin
            col_q  <= col_s_q;
            page_q <= (page_q == pg_e_q) ? pg_s_q : page_q + PAGE_ONE;
          end else begin
            col_q <= col_q + COL_ONE;
          end
        end
        VERT: begin
          if (page_q == pg_e_q) begin
            page_q <= pg_s_q;
            col_q  <= (col_q == col_e_q) ? col_s_q : col_q + COL_ONE;
          end else begin
            page_q <= page_q + PAGE_ONE;
          end
        end
        default: col_q <= col_q + COL_ONE;
      endcase
    end else if (ctrl.set_mode) begin
      mode_q <= addr_mode_t'(rx_byte[1:0]);
    end else if (ctrl.set_col_s) begin
      col_s_q <= CW'(rx_byte);
    end else if (ctrl.set_col_e) begin
      col_e_q <= CW'(rx_byte);
      col_q   <= col_s_q;
    end else if (ctrl.set_pg_s) begin
      pg_s_q <= PW'(rx_byte);
    end else if (ctrl.set_pg_e) begin
      pg_e_q <= PW'(rx_byte);
      page_q <= pg_s_q;
    end else if (ctrl.set_page_b) begin
      page_q <= PW'(rx_byte[2:0]);
    end else if (ctrl.set_col_lo) begin
      col_q <= CW'({col_ext[7:4], rx_byte[3:0]});
    end else if (ctrl.set_col_hi) begin
      col_q <= CW'({rx_byte[3:0], col_ext[3:0]});
    end else if (ctrl.set_disp) begin
      disp_q <= rx_byte[0];
    end
  end

  assign o_Byte       = rx_byte;
  assign o_Byte_DV    = rx_dv;
  assign o_Is_Data    = rx_is_data;
  assign o_Wr_En      = ctrl.wr;
  assign o_Wr_Addr    = {page_q, col_q};
  assign o_Wr_Data    = rx_byte;
  assign o_Display_On = disp_q;

endmodule

// File: tb/tb_ssd1306_rx.sv
// ----------------------------------------------------------------------------
// tb_ssd1306_rx
//   Self-checking bench for ssd1306_rx (COLS=128, PAGES=8, SYNC_STAGES=2).
//   A table of SPI bytes with hand-computed write addresses and display
//   state is applied in order, followed by hand-written reset-mid-byte and
//   (with SSD1306_RX_CS_EN) chip-select abort sequences.
// ----------------------------------------------------------------------------
module tb_ssd1306_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sck;
  logic       mosi;
  logic       dc;
`ifdef SSD1306_RX_CS_EN
  logic       cs_n;
`endif
  logic [7:0] byte_o;
  logic       byte_dv;
  logic       is_data;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       disp_on;

  ssd1306_rx #(
    .COLS        (128),
    .PAGES       (8),
    .SYNC_STAGES (2)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_SPI_Clk    (sck),
    .i_SPI_MOSI   (mosi),
    .i_DC         (dc),
`ifdef SSD1306_RX_CS_EN
    .i_CS_n       (cs_n),
`endif
    .o_Byte       (byte_o),
    .o_Byte_DV    (byte_dv),
    .o_Is_Data    (is_data),
    .o_Wr_En      (wr_en),
    .o_Wr_Addr    (wr_addr),
    .o_Wr_Data    (wr_data),
    .o_Display_On (disp_on)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Capture every byte-valid pulse on the falling edge.
  int         dv_cnt = 0;
  int         wr_cnt = 0;
  logic [7:0] cap_byte;
  logic       cap_is_data;
  logic       cap_wr;
  logic [9:0] cap_addr;
  logic [7:0] cap_data;

  always @(negedge clk) begin
    if (wr_en) wr_cnt++;
    if (byte_dv) begin
      dv_cnt++;
      cap_byte    = byte_o;
      cap_is_data = is_data;
      cap_wr      = wr_en;
      cap_addr    = wr_addr;
      cap_data    = wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic spi_bit(input logic d, input logic b);
    mosi = b;
    dc   = d;
    repeat (3) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
    sck = 1'b0;
  endtask

  // Sends one byte and checks everything observable about it.
  task automatic xfer(input string tag, input logic d, input logic [7:0] b,
                      input logic [9:0] exp_addr, input logic exp_disp);
    int base_dv;
    int base_wr;
    base_dv = dv_cnt;
    base_wr = wr_cnt;
    for (int i = 7; i >= 0; i--) spi_bit(d, b[i]);
    for (int t = 0; t < 40 && dv_cnt == base_dv; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({tag, " dv_pulses"}, dv_cnt - base_dv, 1);
    check({tag, " byte"}, cap_byte, b);
    check({tag, " is_data"}, cap_is_data, d);
    check({tag, " wr_en"}, cap_wr, d);
    check({tag, " wr_pulses"}, wr_cnt - base_wr, d ? 1 : 0);
    if (d) begin
      check({tag, " wr_addr"}, cap_addr, exp_addr);
      check({tag, " wr_data"}, cap_data, b);
    end
    check({tag, " display_on"}, disp_on, exp_disp);
  endtask

  typedef struct {
    logic       dc;
    logic [7:0] b;
    logic [9:0] addr;
    logic       disp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic d, input logic [7:0] b,
                              input logic [9:0] addr, input logic disp);
    vec_t v;
    v.dc = d; v.b = b; v.addr = addr; v.disp = disp;
    vecs.push_back(v);
  endfunction

  initial begin
    // Power-on: page mode at (0,0).
    add(1, 8'hA5, 10'd0, 0);   add(1, 8'h11, 10'd1, 0);
    // Horizontal, cols 126..127, pages 6..7.
    add(0, 8'h20, 0, 0); add(0, 8'h00, 0, 0); add(0, 8'h21, 0, 0); add(0, 8'h7E, 0, 0);
    add(0, 8'h7F, 0, 0); add(0, 8'h22, 0, 0); add(0, 8'h06, 0, 0); add(0, 8'h07, 0, 0);
    add(1, 8'h01, 10'd894, 0); add(1, 8'h02, 10'd895, 0); add(1, 8'h03, 10'd1022, 0);
    add(1, 8'h04, 10'd1023, 0); add(1, 8'h05, 10'd894, 0);
    // Vertical, cols 0..1, pages 0..1.
    add(0, 8'h20, 0, 0); add(0, 8'h01, 0, 0); add(0, 8'h21, 0, 0); add(0, 8'h00, 0, 0);
    add(0, 8'h01, 0, 0); add(0, 8'h22, 0, 0); add(0, 8'h00, 0, 0); add(0, 8'h01, 0, 0);
    add(1, 8'h10, 10'd0, 0); add(1, 8'h11, 10'd128, 0); add(1, 8'h12, 10'd1, 0);
    add(1, 8'h13, 10'd129, 0); add(1, 8'h14, 10'd0, 0);
    // Page mode, page 3, col 0x7F via nibbles; column wraps to 0.
    add(0, 8'h20, 0, 0); add(0, 8'h02, 0, 0); add(0, 8'hB3, 0, 0); add(0, 8'h0F, 0, 0);
    add(0, 8'h17, 0, 0);
    add(1, 8'h20, 10'd511, 0); add(1, 8'h21, 10'd384, 0);
    // Data aborts a pending 0x21; the following 0x00 is a col-low command.
    add(0, 8'h21, 0, 0);
    add(1, 8'h55, 10'd385, 0); add(1, 8'h56, 10'd386, 0);
    add(0, 8'h00, 0, 0);
    add(1, 8'h57, 10'd384, 0);
    // 0x81 swallows its argument, so 0x00 does not reset the column.
    add(0, 8'h81, 0, 0); add(0, 8'h00, 0, 0);
    add(1, 8'h58, 10'd385, 0);
    // Mode argument 3 is ignored: still page mode.
    add(0, 8'h20, 0, 0); add(0, 8'h03, 0, 0);
    add(1, 8'h59, 10'd386, 0);
    // Display on/off.
    add(0, 8'hAF, 0, 1);
    add(1, 8'h5A, 10'd387, 1);
    add(0, 8'hAE, 0, 0); add(0, 8'hAF, 0, 1);

    rst  = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    dc   = 1'b0;
`ifdef SSD1306_RX_CS_EN
    cs_n = 1'b0;
`endif
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("reset byte", byte_o, 8'h00);
    check("reset byte_dv", byte_dv, 1'b0);
    check("reset wr_en", wr_en, 1'b0);
    check("reset wr_addr", wr_addr, 10'd0);
    check("reset display_on", disp_on, 1'b0);

    foreach (vecs[i]) begin
      xfer($sformatf("vec%0d", i), vecs[i].dc, vecs[i].b, vecs[i].addr, vecs[i].disp);
    end

    // Reset after 5 bits: the partial byte is lost, pointers return to 0.
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid display_on", disp_on, 1'b0);
    check("rst_mid wr_addr", wr_addr, 10'd0);
    check("rst_mid byte", byte_o, 8'h00);
    xfer("rst_mid", 1'b1, 8'h3C, 10'd0, 1'b0);

`ifdef SSD1306_RX_CS_EN
    // CS_n high mid-argument discards the partial byte but keeps the FSM
    // waiting for the column-start argument.
    xfer("cs_cmd21", 1'b0, 8'h21, 10'd0, 1'b0);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) spi_bit(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    xfer("cs_col_s", 1'b0, 8'h05, 10'd0, 1'b0);
    xfer("cs_col_e", 1'b0, 8'h07, 10'd0, 1'b0);
    xfer("cs_data", 1'b1, 8'hC3, 10'd5, 1'b0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
